// File: rtl/rns_pkg.sv
// rtl/rns_pkg.sv - shared constants and modulus-(2^(2N)-1) helpers for the RNS reverse converter
package rns_pkg;

  localparam int N_MAX = 32;
  localparam int W_MAX = 2 * N_MAX;
  localparam int N_DEF = 20;

  typedef logic [W_MAX-1:0]   word_t;
  typedef logic [3*N_MAX-1:0] wide_t;

  localparam word_t MOD_HI = (word_t'(1) << (2 * N_DEF)) - word_t'(1);
  localparam wide_t M = ((wide_t'(1) << N_DEF) + wide_t'(1)) * (wide_t'(1) << N_DEF) *
                        ((wide_t'(1) << N_DEF) - wide_t'(1));

  // Loop form keeps w == W_MAX legal without an oversized shift.
  function automatic word_t low_mask(input int w);
    word_t m;
    m = '0;
    for (int i = 0; i < W_MAX; i++)
      if (i < w) m[i] = 1'b1;
    return m;
  endfunction

  function automatic word_t eac_add(input word_t a, input word_t b, input int w);
    logic [W_MAX:0] s;
    logic [W_MAX:0] c;
    word_t          m;
    word_t          r;
    m = low_mask(w);
    s = {1'b0, a & m} + {1'b0, b & m};
    c = s >> w;
    r = (s[W_MAX-1:0] & m) + word_t'(c[0]);
    return r & m;
  endfunction

  // {z, z} rotated right by one bit inside a 2n-bit word.
  function automatic word_t rot_dup(input word_t z, input int n);
    word_t d;
    word_t m;
    m = low_mask(2 * n);
    d = ((z << n) | z) & m;
    return ((d >> 1) | (word_t'(d[0]) << (2 * n - 1))) & m;
  endfunction

  function automatic word_t a1_word(input word_t x1, input int n);
    word_t hi;
    word_t z;
    hi = x1 >> n;
    z  = (x1 & low_mask(n) & ~word_t'(1)) | word_t'(hi[0] ^ x1[0]);
    return rot_dup(z, n);
  endfunction

  function automatic word_t a2_word(input word_t x2, input int n);
    word_t m;
    m = low_mask(n);
    return (((~x2) & m) << n) | m;
  endfunction

  function automatic word_t a3_word(input word_t x3, input int n);
    return rot_dup(x3 & low_mask(n), n);
  endfunction

endpackage

// File: rtl/rns_mod_add_2n1.sv
// rtl/rns_mod_add_2n1.sv - combinational end-around-carry adder modulo 2^W-1
module rns_mod_add_2n1
  import rns_pkg::*;
#(
  parameter int W = 40
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s
);

  assign s = W'(eac_add(word_t'(a), word_t'(b), W));

endmodule

// File: rtl/rns_reverse_converter_pipe.sv
// rtl/rns_reverse_converter_pipe.sv - 3-stage {2^N+1, 2^N, 2^N-1} reverse converter; RNS_REVERSE_RANGE_CHECK_EN adds out_err
module rns_reverse_converter_pipe
  import rns_pkg::*;
#(
  parameter int N = 20
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N:0]     x1,
  input  logic [N-1:0]   x2,
  input  logic [N-1:0]   x3,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [3*N-1:0] out,
  output logic           out_err
);

  localparam int W     = 2 * N;
  localparam int OUT_W = 3 * N;

  logic         v1, v2;
  logic         load1, load2, load3;
  logic [N:0]   s1_x1;
  logic [N-1:0] s1_x2, s2_x2;
  logic [W-1:0] s1_a1, s1_a2, s1_a3;
  logic [W-1:0] s2_s11, s2_s12;
  logic [W-1:0] x1_neg, s11_c, s12_c, y_c, y_n;

  // Each stage refills whenever it is empty, so bubbles collapse under a stall.
  assign load3    = !out_valid || out_ready;
  assign load2    = !v2 || load3;
  assign load1    = !v1 || load2;
  assign in_ready = load1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      s1_x1 <= '0;
      s1_x2 <= '0;
      s1_a1 <= '0;
      s1_a2 <= '0;
      s1_a3 <= '0;
    end else if (load1) begin
      v1    <= in_valid;
      s1_x1 <= x1;
      s1_x2 <= x2;
      s1_a1 <= W'(a1_word(word_t'(x1), N));
      s1_a2 <= W'(a2_word(word_t'(x2), N));
      s1_a3 <= W'(a3_word(word_t'(x3), N));
    end
  end

  // One's complement of x1 is its additive inverse modulo 2^W-1.
  assign x1_neg = ~(W'(s1_x1));

  rns_mod_add_2n1 #(.W(W)) u_add_s11 (.a(s1_a1), .b(x1_neg), .s(s11_c));
  rns_mod_add_2n1 #(.W(W)) u_add_s12 (.a(s1_a2), .b(s1_a3),  .s(s12_c));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2     <= 1'b0;
      s2_x2  <= '0;
      s2_s11 <= '0;
      s2_s12 <= '0;
    end else if (load2) begin
      v2     <= v1;
      s2_x2  <= s1_x2;
      s2_s11 <= s11_c;
      s2_s12 <= s12_c;
    end
  end

  rns_mod_add_2n1 #(.W(W)) u_add_y (.a(s2_s11), .b(s2_s12), .s(y_c));

  // All-ones is the redundant zero of the EAC adder and must not reach out.
  assign y_n = (y_c == {W{1'b1}}) ? '0 : y_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
    end else if (load3) begin
      out_valid <= v2;
      out       <= OUT_W'({y_n, s2_x2});
    end
  end

`ifdef RNS_REVERSE_RANGE_CHECK_EN
  logic s1_err, s2_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_err  <= 1'b0;
      s2_err  <= 1'b0;
      out_err <= 1'b0;
    end else begin
      if (load1) s1_err  <= (x1 > {1'b1, {N{1'b0}}});
      if (load2) s2_err  <= s1_err;
      if (load3) out_err <= s2_err;
    end
  end
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_rns_reverse_converter_pipe.sv
// tb/tb_rns_reverse_converter_pipe.sv - scoreboard bench for rns_reverse_converter_pipe
module tb_rns_reverse_converter_pipe;

  localparam int N  = 20;
  localparam int OW = 3 * N;
`ifdef RNS_REVERSE_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct {
    logic [63:0] x;
    logic        chk;
    logic        err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic          in_ready, out_valid, out_err;
  logic [N:0]    x1 = '0;
  logic [N-1:0]  x2 = '0;
  logic [N-1:0]  x3 = '0;
  logic [OW-1:0] out;

  exp_t q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  bit   sweep_on;

  logic [63:0] m1, m2, m3, mm;

  always #5 clk = ~clk;

  rns_reverse_converter_pipe #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x1       (x1),
    .x2       (x2),
    .x3       (x3),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .out_err  (out_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Handshakes are decided at the coming posedge; inputs are stable at the negedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          if (q[0].chk) check("out", 64'(out), q[0].x);
          check("out_err", 64'(out_err), 64'(q[0].err));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(cur);
    end
  end

  task automatic drive(input logic [N:0] a1, input logic [N-1:0] a2, input logic [N-1:0] a3,
                       input exp_t e);
    int n;
    n = 0;
    x1 = a1;
    x2 = a2;
    x3 = a3;
    cur = e;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_x(input logic [63:0] xv);
    exp_t e;
    e.x   = xv;
    e.chk = 1'b1;
    e.err = 1'b0;
    drive((N+1)'(xv % m1), N'(xv % m2), N'(xv % m3), e);
  endtask

  function automatic logic [63:0] rand_x();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r % mm;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    m1 = (64'd1 << N) + 64'd1;
    m2 = 64'd1 << N;
    m3 = (64'd1 << N) - 64'd1;
    mm = m1 * m2 * m3;

    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out", 64'(out), 64'd0);
    check("reset_out_err", 64'(out_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    send_x(64'd123456789);
    in_valid = 1'b0;
    check("lat_valid_c1", 64'(out_valid), 64'd0);
    check("lat_out_c1", 64'(out), 64'd0);
    @(posedge clk);
    #1;
    check("lat_valid_c2", 64'(out_valid), 64'd0);
    check("lat_out_c2", 64'(out), 64'd0);
    @(posedge clk);
    #1;
    check("lat_valid_c3", 64'(out_valid), 64'd1);
    check("lat_out_c3", 64'(out), 64'd123456789);
    drain();

    send_x(64'd0);
    send_x(mm - 64'd1);
    send_x(64'd1 << N);
    e.x = 64'd0;
    e.chk = 1'b1;
    e.err = 1'b0;
    drive('0, '0, N'(m3), e);
    drain();

    fork
      begin
        for (int i = 0; i < 10; i++) send_x(rand_x());
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_x(rand_x());
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    check("midreset_queue", 64'(q.size()), 64'd0);

    e.x = 64'd0;
    e.chk = 1'b0;
    e.err = RC;
    drive((N+1)'((64'd1 << N) + 64'd5), N'(7), N'(9), e);
    send_x(64'd987654321);
    drain();

    sweep_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
          send_x(rand_x());
        end
        in_valid = 1'b0;
        sweep_on = 1'b0;
      end
      begin
        while (sweep_on) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rns_reverse_converter_pipe.md
Name: rns_reverse_converter_pipe

Overview:
- Parametrised, pipelined reverse converter for the moduli set {2^N+1, 2^N, 2^N-1}.
- Turns a residue triple (x1, x2, x3) into its binary value X in [0, M), where M = (2^N+1)·2^N·(2^N-1).
- Replaces the fixed N=20 combinational converter. Adds a valid/ready stream interface, 3-stage pipeline, per-stage bubble collapse and backpressure.
- Sits at the output of the RNS datapath, before binary-domain logic.

Parameters:
- N, 20, residue base width; legal range 4..32.
- OUT_W, 3*N, output width; fixed by N, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input triple valid
- in_ready  out  1  converter accepts the triple this cycle
- x1  in  N+1  residue mod 2^N+1, legal 0..2^N
- x2  in  N  residue mod 2^N
- x3  in  N  residue mod 2^N-1; 2^N-1 is treated as 0
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out  out  3N  X
- out_err  out  1  range error flag travelling with the result (see Optional Feature)

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset: all stage valids are 0; out, out_err and all data registers are 0; in_ready is 1 the cycle after reset is released. Reset asserted mid-operation discards all in-flight data. No partial result is emitted.
- Arithmetic: X = x2 + 2^N·Y, where Y = |A1 + A2 + A3|_(2^(2N)-1).
  - A1 = |2^(2N-1)(2^N+1)·x1 - x1|. Bit form: bx = x1[N]^x1[0]; word {bx, x1[N-1:1], bx, x1[N-1:1]}; then subtract x1.
  - A2 = {~x2, N ones}, which equals |-2^N·x2|.
  - A3 = {x3[0], x3[N-1:1], x3[0], x3[N-1:1]}.
  - Every modular add is an end-around-carry (mod 2^(2N)-1) adder; all-ones is an equivalent representation of 0.
  - The final output must never contain Y = 2^(2N)-1; stage 3 normalises it to 0.
- Pipeline, latency 3 cycles from accept to out_valid when there is no backpressure:
  - S1: register x2 and A1, A2, A3.
  - S2: register S12 = |A2+A3| and S11 = |A1-x1|, plus x2.
  - S3: register Y = |S11+S12|, normalise it, and form out = {Y, x2}.
- Handshake:
  - Each stage holds a valid bit. Stage k loads when its valid is 0 or stage k+1 loads this cycle. S3 loads when !out_valid || out_ready.
  - in_ready = S1 loads. A transfer occurs when in_valid && in_ready.
  - Bubbles collapse: an empty stage is refilled even while a later stage is stalled.
  - out and out_err are stable while out_valid && !out_ready.
  - Throughput is 1 result per cycle with out_ready held high.
  - Simultaneous accept and emit in the same cycle is legal; there is no duplication or loss.
  - in_ready is combinational from out_ready; there is no skid buffer. Full stall with all 3 stages valid gives in_ready = 0.

Optional Feature:
- Macro: RNS_REVERSE_RANGE_CHECK_EN.
- Defined: S1 sets err = (x1 > 2^N). err travels with its data through S2/S3 and drives out_err alongside out_valid. out is still computed.
- Undefined: out_err is tied to 0 and no compare logic is built.
- Behaviour is otherwise identical in both builds.

Decomposition:
- Package rns_pkg: the function for the modulus-(2^(2N)-1) end-around-carry add, the A1/A2/A3 coefficient-builder functions, and the localparams MOD_HI and M.
- One sub-module, rns_mod_add_2n1 (parametrised width 2N, combinational end-around-carry adder). It is instantiated three times: S2 twice, S3 once.
- Stage valid/load control stays in the top module.

Test Plan:
- Reset and latency: N=20, hold rst_n=0 for 2 cycles, then send X=123456789 as residues (x1=123456789 mod 1048577, etc.), out_ready=1 -> out_valid rises exactly 3 cycles after accept with out=123456789; before that out=0 and out_valid=0.
- Boundary values: N=20, stream X=0, X=M-1, and x3=2^N-1 with x1=x2=0 (≡0) -> outputs are 0, M-1 and 0 respectively, with no all-ones Y.
- Backpressure and bubbles: N=8, send 10 random values back to back, drop out_ready for 5 cycles mid-stream -> in_ready falls after the 3 stages fill, bubbles collapse, results come out in order, none lost or duplicated, and out is stable during the stall.
- Reset mid-flight: 3 values in the pipe, pulse rst_n low for 1 cycle -> out_valid=0 next cycle and none of the 3 values ever appears.
- Random sweep: N ∈ {4, 8, 20, 32}, 10k random X with random in_valid/out_ready -> every out matches a golden CRT model.
- Range check, built with RNS_REVERSE_RANGE_CHECK_EN: N=8, x1=300 -> out_err=1 on that result only; without the macro, out_err=0 always.
